// File: rtl/sd_bmp_pixel_unpack_pkg.sv
// Shared types and helpers for the BMP sector-stream pixel unpacker.
// Holds the byte-level state enum and the BGR888/RGB565 helpers.
package sd_bmp_pkg;

  localparam int BMP_HDR_BYTES = 54;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PIX,
    PAD,
    DONE
  } state_t;

  function automatic logic [15:0] rgb888_to_565(
    input logic [7:0] r,
    input logic [7:0] g,
    input logic [7:0] b
  );
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

  // BMP rows are padded to a 4-byte multiple
  function automatic int bmp_row_pad(input int h_pix);
    return (4 - ((3 * h_pix) % 4)) % 4;
  endfunction

endpackage

// File: rtl/sd_bmp_pixel_unpack_if.sv
// Sector-data in / pixel-stream out bundle of the BMP unpacker.
// master drives sector words, slave produces pixels.
interface sd_bmp_pixel_unpack_if;
  logic        pic_start;
  logic        rd_data_en;
  logic [15:0] rd_data;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        one_pic_wr_end;
  logic        busy;

  modport master (
    output pic_start, rd_data_en, rd_data,
    input  pix_valid, pix_data, one_pic_wr_end, busy
  );

  modport slave (
    input  pic_start, rd_data_en, rd_data,
    output pix_valid, pix_data, one_pic_wr_end, busy
  );
endinterface

// File: rtl/sd_bmp_pixel_unpack_byte_step.sv
// Combinational next-state for one file byte of the BMP unpacker.
// Chained twice per word; owns no registers.
module bmp_byte_step
  import sd_bmp_pkg::*;
#(
  parameter int H_PIX     = 1920,
  parameter int V_PIX     = 1080,
  parameter int HDR_BYTES = BMP_HDR_BYTES,
  parameter int CW        = 11,
  parameter int RW        = 11,
  parameter int HW        = 6
) (
  input  logic          i_en,
  input  logic [7:0]    i_byte,
  input  state_t        i_state,
  input  logic [HW-1:0] i_hdr_cnt,
  input  logic [CW-1:0] i_col,
  input  logic [RW-1:0] i_row,
  input  logic [1:0]    i_pad_cnt,
  input  logic [1:0]    i_phase,
  input  logic [7:0]    i_b,
  input  logic [7:0]    i_g,
  output state_t        o_state,
  output logic [HW-1:0] o_hdr_cnt,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic [1:0]    o_pad_cnt,
  output logic [1:0]    o_phase,
  output logic [7:0]    o_b,
  output logic [7:0]    o_g,
  output logic          o_emit,
  output logic          o_last,
  output logic [15:0]   o_pix
);

  localparam int            ROW_PAD  = bmp_row_pad(H_PIX);
  localparam logic [HW-1:0] HDR_LAST = HW'(HDR_BYTES - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(H_PIX - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_PIX - 1);
  localparam logic [1:0]    PAD_LAST = 2'(ROW_PAD - 1);

  always_comb begin
    o_state   = i_state;
    o_hdr_cnt = i_hdr_cnt;
    o_col     = i_col;
    o_row     = i_row;
    o_pad_cnt = i_pad_cnt;
    o_phase   = i_phase;
    o_b       = i_b;
    o_g       = i_g;
    o_emit    = 1'b0;
    o_last    = 1'b0;
    o_pix     = rgb888_to_565(i_byte, i_g, i_b);
    if (i_en) begin
      unique case (i_state)
        HDR: begin
          o_hdr_cnt = i_hdr_cnt + HW'(1);
          if (i_hdr_cnt == HDR_LAST) o_state = PIX;
        end
        PIX: begin
          unique case (i_phase)
            2'd0: begin
              o_b     = i_byte;
              o_phase = 2'd1;
            end
            2'd1: begin
              o_g     = i_byte;
              o_phase = 2'd2;
            end
            default: begin
              o_emit  = 1'b1;
              o_phase = 2'd0;
              if (i_col != COL_LAST) begin
                o_col = i_col + CW'(1);
              end else if (i_row == ROW_LAST) begin
                o_state = DONE;
                o_last  = 1'b1;
              end else if (ROW_PAD > 0) begin
                o_state   = PAD;
                o_pad_cnt = 2'd0;
              end else begin
                o_row = i_row + RW'(1);
                o_col = '0;
              end
            end
          endcase
        end
        PAD: begin
          if (i_pad_cnt == PAD_LAST) begin
            o_pad_cnt = 2'd0;
            o_row     = i_row + RW'(1);
            o_col     = '0;
            o_state   = PIX;
          end else begin
            o_pad_cnt = i_pad_cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sd_bmp_pixel_unpack.sv
// BMP sector stream to RGB565 pixel stream: header strip, row unpad, pack.
// Registers live here; two byte steps per accepted word.
module sd_bmp_pixel_unpack
  import sd_bmp_pkg::*;
#(
  parameter int H_PIX     = 1920,
  parameter int V_PIX     = 1080,
  parameter int HDR_BYTES = BMP_HDR_BYTES
) (
  input logic                  sys_clk,
  input logic                  sys_rst,
  sd_bmp_pixel_unpack_if.slave bus
);

  localparam int CW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
  localparam int RW = (V_PIX > 1) ? $clog2(V_PIX) : 1;
  localparam int HW = (HDR_BYTES > 0) ? $clog2(HDR_BYTES + 1) : 1;

  state_t        r_state;
  logic [HW-1:0] r_hdr_cnt;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [1:0]    r_pad_cnt;
  logic [1:0]    r_phase;
  logic [7:0]    r_b;
  logic [7:0]    r_g;
  logic          r_pix_valid;
  logic [15:0]   r_pix_data;
  logic          r_end;
  logic          r_busy;

  state_t        w_s0_state;
  logic [HW-1:0] w_s0_hdr;
  logic [CW-1:0] w_s0_col;
  logic [RW-1:0] w_s0_row;
  logic [1:0]    w_s0_pad;
  logic [1:0]    w_s0_ph;
  logic [7:0]    w_s0_b;
  logic [7:0]    w_s0_g;

  state_t        w_s1_state;
  logic [HW-1:0] w_s1_hdr;
  logic [CW-1:0] w_s1_col;
  logic [RW-1:0] w_s1_row;
  logic [1:0]    w_s1_pad;
  logic [1:0]    w_s1_ph;
  logic [7:0]    w_s1_b;
  logic [7:0]    w_s1_g;
  logic          w_s1_emit;
  logic          w_s1_last;
  logic [15:0]   w_s1_pix;

  state_t        w_s2_state;
  logic [HW-1:0] w_s2_hdr;
  logic [CW-1:0] w_s2_col;
  logic [RW-1:0] w_s2_row;
  logic [1:0]    w_s2_pad;
  logic [1:0]    w_s2_ph;
  logic [7:0]    w_s2_b;
  logic [7:0]    w_s2_g;
  logic          w_s2_emit;
  logic          w_s2_last;
  logic [15:0]   w_s2_pix;

  logic          w_upd;
  state_t        w_nxt_state;

  // pic_start restarts the image before the coincident word is stepped
  always_comb begin
    w_s0_state = r_state;
    w_s0_hdr   = r_hdr_cnt;
    w_s0_col   = r_col;
    w_s0_row   = r_row;
    w_s0_pad   = r_pad_cnt;
    w_s0_ph    = r_phase;
    w_s0_b     = r_b;
    w_s0_g     = r_g;
    if (bus.pic_start) begin
      w_s0_state = (HDR_BYTES == 0) ? PIX : HDR;
      w_s0_hdr   = '0;
      w_s0_col   = '0;
      w_s0_row   = '0;
      w_s0_pad   = '0;
      w_s0_ph    = '0;
      w_s0_b     = '0;
      w_s0_g     = '0;
    end
  end

  bmp_byte_step #(
    .H_PIX(H_PIX), .V_PIX(V_PIX), .HDR_BYTES(HDR_BYTES),
    .CW(CW), .RW(RW), .HW(HW)
  ) u_step_hi (
    .i_en(bus.rd_data_en), .i_byte(bus.rd_data[15:8]),
    .i_state(w_s0_state), .i_hdr_cnt(w_s0_hdr),
    .i_col(w_s0_col), .i_row(w_s0_row),
    .i_pad_cnt(w_s0_pad), .i_phase(w_s0_ph),
    .i_b(w_s0_b), .i_g(w_s0_g),
    .o_state(w_s1_state), .o_hdr_cnt(w_s1_hdr),
    .o_col(w_s1_col), .o_row(w_s1_row),
    .o_pad_cnt(w_s1_pad), .o_phase(w_s1_ph),
    .o_b(w_s1_b), .o_g(w_s1_g),
    .o_emit(w_s1_emit), .o_last(w_s1_last), .o_pix(w_s1_pix)
  );

  bmp_byte_step #(
    .H_PIX(H_PIX), .V_PIX(V_PIX), .HDR_BYTES(HDR_BYTES),
    .CW(CW), .RW(RW), .HW(HW)
  ) u_step_lo (
    .i_en(bus.rd_data_en), .i_byte(bus.rd_data[7:0]),
    .i_state(w_s1_state), .i_hdr_cnt(w_s1_hdr),
    .i_col(w_s1_col), .i_row(w_s1_row),
    .i_pad_cnt(w_s1_pad), .i_phase(w_s1_ph),
    .i_b(w_s1_b), .i_g(w_s1_g),
    .o_state(w_s2_state), .o_hdr_cnt(w_s2_hdr),
    .o_col(w_s2_col), .o_row(w_s2_row),
    .o_pad_cnt(w_s2_pad), .o_phase(w_s2_ph),
    .o_b(w_s2_b), .o_g(w_s2_g),
    .o_emit(w_s2_emit), .o_last(w_s2_last), .o_pix(w_s2_pix)
  );

  assign w_upd       = bus.pic_start | bus.rd_data_en;
  assign w_nxt_state = w_upd ? w_s2_state : r_state;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= IDLE;
      r_hdr_cnt   <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_pad_cnt   <= '0;
      r_phase     <= '0;
      r_b         <= '0;
      r_g         <= '0;
      r_pix_valid <= 1'b0;
      r_pix_data  <= '0;
      r_end       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_pix_valid <= w_s1_emit | w_s2_emit;
      r_end       <= w_s1_last | w_s2_last;
      r_busy      <= (w_nxt_state != IDLE) && (w_nxt_state != DONE);
      if (w_s1_emit) r_pix_data <= w_s1_pix;
      else if (w_s2_emit) r_pix_data <= w_s2_pix;
      if (w_upd) begin
        r_state   <= w_s2_state;
        r_hdr_cnt <= w_s2_hdr;
        r_col     <= w_s2_col;
        r_row     <= w_s2_row;
        r_pad_cnt <= w_s2_pad;
        r_phase   <= w_s2_ph;
        r_b       <= w_s2_b;
        r_g       <= w_s2_g;
      end
    end
  end

  assign bus.pix_valid      = r_pix_valid;
  assign bus.pix_data       = r_pix_data;
  assign bus.one_pic_wr_end = r_end;
  assign bus.busy           = r_busy;

endmodule

// File: tb/tb_sd_bmp_pixel_unpack.sv
// Directed bench for sd_bmp_pixel_unpack on a 3x2 image.
// Instance a uses a 54-byte header, instance b a 55-byte header.
module tb_sd_bmp_pixel_unpack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st  = 1'b0;
  logic        en  = 1'b0;
  logic [15:0] dat = '0;

  always #5 clk = ~clk;

  sd_bmp_pixel_unpack_if ifa ();
  sd_bmp_pixel_unpack_if ifb ();

  assign ifa.pic_start  = st;
  assign ifa.rd_data_en = en;
  assign ifa.rd_data    = dat;
  assign ifb.pic_start  = st;
  assign ifb.rd_data_en = en;
  assign ifb.rd_data    = dat;

  sd_bmp_pixel_unpack #(.H_PIX(3), .V_PIX(2), .HDR_BYTES(54)) dut_a (
    .sys_clk(clk), .sys_rst(rst), .bus(ifa.slave)
  );

  sd_bmp_pixel_unpack #(.H_PIX(3), .V_PIX(2), .HDR_BYTES(55)) dut_b (
    .sys_clk(clk), .sys_rst(rst), .bus(ifb.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  int enda, endb, endia, endib;

  always @(negedge clk) begin
    if (ifa.pix_valid) qa.push_back(ifa.pix_data);
    if (ifa.one_pic_wr_end) begin
      enda++;
      endia = qa.size() - 1;
    end
    if (ifb.pix_valid) qb.push_back(ifb.pix_data);
    if (ifb.one_pic_wr_end) begin
      endb++;
      endib = qb.size() - 1;
    end
  end

  task automatic clr();
    qa.delete(); qb.delete();
    enda = 0; endb = 0; endia = -1; endib = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] bq[$];

  task automatic add_px(input logic [7:0] b, g, r);
    bq.push_back(b); bq.push_back(g); bq.push_back(r);
  endtask

  task automatic img_ffff(input int hdr);
    bq.delete();
    repeat (hdr) bq.push_back(8'h42);
    repeat (2) begin
      repeat (3) add_px(8'hF8, 8'hFC, 8'hF8);
      repeat (3) bq.push_back(8'hAA);
    end
  endtask

  // mode 0: separate start pulse, 1: start with first word, 2: no start
  task automatic send(input int gmax, input int mode,
                      input int first, input int last);
    int nw;
    int hi;
    nw = (bq.size() + 1) / 2;
    hi = (last < nw - 1) ? last : nw - 1;
    if (mode == 0) begin
      st = 1'b1; tick(); st = 1'b0;
    end
    for (int i = first; i <= hi; i++) begin
      dat[15:8] = bq[2*i];
      dat[7:0]  = (2*i + 1 < bq.size()) ? bq[2*i+1] : 8'h00;
      en = 1'b1;
      st = (mode == 1) && (i == first);
      tick();
      en = 1'b0; st = 1'b0;
      if (gmax > 0) repeat ($urandom_range(gmax, 1)) tick();
    end
  endtask

  task automatic chk_img(input string t, input logic [15:0] q[$],
                         input logic [15:0] e[6], input int ec, input int ei);
    check({t, "_count"}, q.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < q.size())
        check($sformatf("%s_pix%0d", t, i), q[i], e[i]);
    check({t, "_end_cnt"}, ec, 1);
    check({t, "_end_idx"}, ei, 5);
  endtask

  logic [15:0] e_ff[6]  = '{16'hFFFF, 16'hFFFF, 16'hFFFF,
                            16'hFFFF, 16'hFFFF, 16'hFFFF};
  logic [15:0] e_pad[6] = '{16'hF821, 16'h07E0, 16'h001F,
                            16'hFFFF, 16'hFFFF, 16'hFFFF};

  initial begin
    clr();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_valid", ifa.pix_valid, 0);
    check("rst_data", ifa.pix_data, 0);
    check("rst_end", ifa.one_pic_wr_end, 0);
    check("rst_busy", ifa.busy, 0);
    check("rst_busy_b", ifb.busy, 0);

    // full image, back-to-back words
    img_ffff(54);
    clr();
    st = 1'b1; tick(); st = 1'b0;
    check("full_busy_rise", ifa.busy, 1);
    send(0, 2, 0, 99);
    repeat (4) tick();
    chk_img("full", qa, e_ff, enda, endia);
    check("full_busy_fall", ifa.busy, 0);

    // padding, distinct colours, plus first-pixel latency
    bq.delete();
    repeat (54) bq.push_back(8'h42);
    add_px(8'h08, 8'h04, 8'hF8);
    add_px(8'h00, 8'hFC, 8'h00);
    add_px(8'hF8, 8'h00, 8'h00);
    repeat (3) bq.push_back(8'hAA);
    repeat (3) add_px(8'hF8, 8'hFC, 8'hF8);
    repeat (3) bq.push_back(8'hAA);
    clr();
    send(0, 0, 0, 27);
    repeat (3) tick();
    check("lat_none_yet", qa.size(), 0);
    send(0, 2, 28, 28);
    check("lat_valid", ifa.pix_valid, 1);
    check("lat_data", ifa.pix_data, 16'hF821);
    tick();
    check("lat_pulse", ifa.pix_valid, 0);
    send(0, 2, 29, 99);
    repeat (4) tick();
    chk_img("pad", qa, e_pad, enda, endia);

    // odd header length on instance b
    img_ffff(55);
    clr();
    send(0, 0, 0, 99);
    repeat (4) tick();
    chk_img("odd", qb, e_ff, endb, endib);

    // random gaps and trailing sector words
    img_ffff(54);
    repeat (10) begin
      bq.push_back(8'hF8); bq.push_back(8'hFC);
    end
    clr();
    send(5, 0, 0, 99);
    repeat (6) tick();
    chk_img("gap", qa, e_ff, enda, endia);

    // restart mid-image with coincident pic_start
    img_ffff(54);
    clr();
    send(0, 0, 0, 29);
    tick();
    check("abort_pre", qa.size(), 2);
    send(0, 1, 0, 99);
    repeat (4) tick();
    check("abort_count", qa.size(), 8);
    check("abort_end_cnt", enda, 1);
    check("abort_end_idx", endia, 7);
    if (qa.size() == 8) check("abort_last", qa[7], 16'hFFFF);

    // asynchronous reset while a pixel is on the output
    clr();
    send(0, 0, 0, 28);
    check("rst_mid_pre", ifa.pix_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valid", ifa.pix_valid, 0);
    check("rst_mid_data", ifa.pix_data, 0);
    check("rst_mid_busy", ifa.busy, 0);
    check("rst_mid_end", ifa.one_pic_wr_end, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    clr();
    send(0, 0, 0, 99);
    repeat (4) tick();
    chk_img("post_rst", qa, e_ff, enda, endia);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
